regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (wa3/wd3) between two writeback sources: the ALU result path and the load-data return path.
- Holds one deferred ALU write in a buffer and prevents that entry from starving.
- Keeps a load scoreboard and drives a read-hazard stall for decode.
- Sits between execute/memory and the register file; its registered outputs drive wa3/wd3 directly.

Parameters:
REG_SIZE, 32, number of architectural registers; x0 is never written or tracked
STARVE_LIMIT, 3, consecutive cycles the held ALU entry may lose to mem before it is forced through (range 1..15)

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-low
alu_valid  in  1  ALU writeback request
alu_rd  in  5  ALU destination
alu_data  in  32  ALU result
alu_ready  out  1  ALU request accepted this cycle
mem_valid  in  1  load-data writeback request
mem_rd  in  5  load destination
mem_data  in  32  load data
mem_ready  out  1  mem request accepted this cycle
ld_issue  in  1  a load issues this cycle
ld_rd  in  5  destination of the issuing load
ra1  in  5  decode read address 1
ra2  in  5  decode read address 2
stall  out  1  decode must hold
wa3  out  5  regfile write address; 0 means no write
wd3  out  32  regfile write data

Behaviour:
- Reset (reset low, asynchronous):
  - wa3=0, wd3=0.
  - Buffer empty, starve counter 0, all scoreboard bits clear.
  - Combinational outputs take their reset-state values: alu_ready=1, mem_ready=1, stall=0.
- Idle rule: wa3 is 0 on every cycle with no write. The regfile writes whenever wa3 matches a register index, so no stale address may be held.
- Write latency: the winner in cycle N appears on wa3/wd3 in cycle N+1. The regfile captures it at the end of N+1.
- Arbitration, per cycle:
  - force = buf_valid & (starve_cnt == STARVE_LIMIT).
  - Priority when force=0: mem, then held buffer, then fresh ALU.
  - When force=1: the buffer wins.
- mem_ready = !force.
- alu_ready = !buf_valid, based on registered state only. A fresh ALU request is accepted only when the buffer is empty.
- An accepted fresh ALU request that does not win is written into the buffer (buf_valid=1).
- The buffer clears in the cycle it wins.
- Starve counter:
  - Increments each cycle the buffer is valid and loses to mem.
  - Resets to 0 when the buffer wins or is empty.
  - Saturates at STARVE_LIMIT.
- rd==0 requests:
  - Accepted whenever their ready is high.
  - Never win the port, never enter the buffer, produce no write (wa3 stays 0 for them).
- Scoreboard, busy[1..REG_SIZE-1]:
  - ld_issue with ld_rd!=0 sets busy[ld_rd].
  - An accepted mem request with mem_rd!=0 clears busy[mem_rd].
  - Set and clear of the same register in the same cycle: set wins (a newer load).
  - Mem writes to a register that is not busy are still performed.
- Stall: for each x in {ra1, ra2}, hazard(x) = x!=0 & (busy[x] | (buf_valid & buf_rd==x) | (wa3==x)). stall = hazard(ra1) | hazard(ra2), combinational.
- Reset mid-operation: a buffered write is dropped, an in-flight wa3 is forced to 0, and all pending scoreboard bits are lost.

Test Plan:
- ALU only: alu_valid, rd=5, data=0x11 in cycle 1 -> alu_ready=1; cycle 2 wa3=5, wd3=0x11; cycle 3 wa3=0.
- Conflict: alu(rd=3, 0xA) and mem(rd=4, 0xB) in the same cycle -> both ready. Next cycle wa3=4/0xB, alu_ready=0. Following cycle wa3=3/0xA.
- Starvation, STARVE_LIMIT=3: buffer holds rd=7 while mem_valid is held continuously. Mem wins for 3 cycles, then mem_ready=0 for one cycle and wa3=7. Mem resumes on the next cycle.
- Scoreboard: ld_issue rd=9, then ra1=9 -> stall=1 until mem rd=9 is accepted. Stall stays 1 the next cycle (wa3=9), then drops to 0. Same-cycle ld_issue rd=9 with mem rd=9 accepted -> busy[9] remains set.
- x0 handling: alu rd=0 and ra1=ra2=0 -> ready=1, wa3 stays 0, stall=0.
- Reset asserted while the buffer is full and wa3=12 -> wa3=0 immediately, alu_ready=1, stall=0, no write to register 12 after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the ALU and load-return paths,
// with a one-entry anti-starvation ALU buffer and a load scoreboard driving the decode stall.
module regfile_wb_arbiter #(
  parameter int REG_SIZE     = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        ld_issue,
  input  logic [4:0]  ld_rd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        stall,
  output logic [4:0]  wa3,
  output logic [31:0] wd3
);

  logic                buf_valid_reg, buf_valid_next;
  logic [4:0]          buf_rd_reg, buf_rd_next;
  logic [31:0]         buf_data_reg, buf_data_next;
  logic [3:0]          starve_cnt_reg, starve_cnt_next;
  logic [REG_SIZE-1:0] busy_reg, busy_next;
  logic [4:0]          wa3_reg, wa3_next;
  logic [31:0]         wd3_reg, wd3_next;

  logic force_buf;
  logic mem_acc;
  logic mem_write;
  logic alu_write;
  logic hazard1;
  logic hazard2;

  assign force_buf = buf_valid_reg && (starve_cnt_reg == 4'(STARVE_LIMIT));
  assign mem_ready = !force_buf;
  assign alu_ready = !buf_valid_reg;

  // rd==0 requests are accepted (ready high) but never compete for the port.
  assign mem_acc   = mem_valid && mem_ready;
  assign mem_write = mem_acc && (mem_rd != 5'd0);
  assign alu_write = alu_valid && alu_ready && (alu_rd != 5'd0);

  always_comb begin
    buf_valid_next  = buf_valid_reg;
    buf_rd_next     = buf_rd_reg;
    buf_data_next   = buf_data_reg;
    starve_cnt_next = starve_cnt_reg;
    wa3_next        = 5'd0;
    wd3_next        = 32'd0;
    if (force_buf) begin
      wa3_next        = buf_rd_reg;
      wd3_next        = buf_data_reg;
      buf_valid_next  = 1'b0;
      starve_cnt_next = 4'd0;
    end else if (mem_write) begin
      wa3_next = mem_rd;
      wd3_next = mem_data;
      if (buf_valid_reg) begin
        if (starve_cnt_reg != 4'(STARVE_LIMIT))
          starve_cnt_next = starve_cnt_reg + 4'd1;
      end else begin
        starve_cnt_next = 4'd0;
      end
      // A fresh ALU request that loses to mem is parked in the buffer.
      if (alu_write) begin
        buf_valid_next = 1'b1;
        buf_rd_next    = alu_rd;
        buf_data_next  = alu_data;
      end
    end else if (buf_valid_reg) begin
      wa3_next        = buf_rd_reg;
      wd3_next        = buf_data_reg;
      buf_valid_next  = 1'b0;
      starve_cnt_next = 4'd0;
    end else begin
      starve_cnt_next = 4'd0;
      if (alu_write) begin
        wa3_next = alu_rd;
        wd3_next = alu_data;
      end
    end
  end

  // Set beats clear so a newer load to the same register stays tracked.
  assign busy_next[0] = 1'b0;
  for (genvar gi = 1; gi < REG_SIZE; gi++) begin : g_busy
    assign busy_next[gi] = (ld_issue && (ld_rd == 5'(gi))) ||
                           (busy_reg[gi] && !(mem_acc && (mem_rd == 5'(gi))));
  end

  assign hazard1 = (ra1 != 5'd0) &&
                   (busy_reg[ra1] || (buf_valid_reg && (buf_rd_reg == ra1)) || (wa3_reg == ra1));
  assign hazard2 = (ra2 != 5'd0) &&
                   (busy_reg[ra2] || (buf_valid_reg && (buf_rd_reg == ra2)) || (wa3_reg == ra2));
  assign stall   = hazard1 || hazard2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_valid_reg  <= 1'b0;
      buf_rd_reg     <= 5'd0;
      buf_data_reg   <= 32'd0;
      starve_cnt_reg <= 4'd0;
      busy_reg       <= '0;
      wa3_reg        <= 5'd0;
      wd3_reg        <= 32'd0;
    end else begin
      buf_valid_reg  <= buf_valid_next;
      buf_rd_reg     <= buf_rd_next;
      buf_data_reg   <= buf_data_next;
      starve_cnt_reg <= starve_cnt_next;
      busy_reg       <= busy_next;
      wa3_reg        <= wa3_next;
      wd3_reg        <= wd3_next;
    end
  end

  assign wa3 = wa3_reg;
  assign wd3 = wd3_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter, checked against a queue-based
// reference model of the writeback port, deferred ALU entry and load scoreboard.
module tb_regfile_wb_arbiter;

  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        stall;
  logic [4:0]  wa3;
  logic [31:0] wd3;

  regfile_wb_arbiter #(.REG_SIZE(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .ld_issue(ld_issue), .ld_rd(ld_rd), .ra1(ra1), .ra2(ra2), .stall(stall),
    .wa3(wa3), .wd3(wd3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          src;   // 0 = mem, 1 = held entry, 2 = fresh alu
  } ent_t;

  ent_t        m_buf[$];
  int          m_starve;
  bit          m_busy[32];
  logic [4:0]  m_wa3;
  logic [31:0] m_wd3;

  // Values the DUT showed just before the most recent edge
  logic pre_alu_ready, pre_mem_ready, pre_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hazard(input logic [4:0] x);
    bit h;
    h = 1'b0;
    if (x != 0) begin
      if (m_busy[x]) h = 1'b1;
      if (m_wa3 == x) h = 1'b1;
      foreach (m_buf[i]) if (m_buf[i].rd == x) h = 1'b1;
    end
    return h;
  endfunction

  task automatic model_reset();
    m_buf.delete();
    m_starve = 0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_wa3 = 5'd0;
    m_wd3 = 32'd0;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    ld_issue = 0; ld_rd = 0; ra1 = 0; ra2 = 0;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    bit   frc, e_alu_ready, e_mem_ready, e_stall, mem_acc, alu_acc;
    ent_t cand[$];
    ent_t e;
    #1;
    frc         = (m_buf.size() != 0) && (m_starve == LIMIT);
    e_mem_ready = !frc;
    e_alu_ready = (m_buf.size() == 0);
    e_stall     = m_hazard(ra1) || m_hazard(ra2);
    pre_alu_ready = alu_ready;
    pre_mem_ready = mem_ready;
    pre_stall     = stall;
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, e_alu_ready});
    chk("mem_ready", {31'd0, mem_ready}, {31'd0, e_mem_ready});
    chk("stall",     {31'd0, stall},     {31'd0, e_stall});

    mem_acc = mem_valid && e_mem_ready;
    alu_acc = alu_valid && e_alu_ready;
    // Candidates in priority order; the head of the list gets the port.
    if (frc) begin e = m_buf[0]; e.src = 1; cand.push_back(e); end
    if (mem_acc && mem_rd != 0) begin e.rd = mem_rd; e.data = mem_data; e.src = 0; cand.push_back(e); end
    if (m_buf.size() != 0) begin e = m_buf[0]; e.src = 1; cand.push_back(e); end
    if (alu_acc && alu_rd != 0) begin e.rd = alu_rd; e.data = alu_data; e.src = 2; cand.push_back(e); end

    m_wa3 = 5'd0;
    m_wd3 = 32'd0;
    if (cand.size() != 0) begin
      m_wa3 = cand[0].rd;
      m_wd3 = cand[0].data;
    end
    if (m_buf.size() != 0) begin
      if (cand[0].src == 1) begin
        void'(m_buf.pop_front());
        m_starve = 0;
      end else begin
        m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
      end
    end else begin
      m_starve = 0;
      if (alu_acc && alu_rd != 0 && cand[0].src != 2) begin
        e.rd = alu_rd; e.data = alu_data; e.src = 1;
        m_buf.push_back(e);
      end
    end
    if (mem_acc && mem_rd != 0) m_busy[mem_rd] = 1'b0;
    if (ld_issue && ld_rd != 0) m_busy[ld_rd] = 1'b1;

    @(posedge clk);
    #1;
    chk("wa3", {27'd0, wa3}, {27'd0, m_wa3});
    if (m_wa3 != 0) chk("wd3", wd3, m_wd3);
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wa3", {27'd0, wa3}, 32'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // ALU only
    idle(); alu_valid = 1; alu_rd = 5; alu_data = 32'h11;
    tick();
    chk("alu_only_ready", {31'd0, pre_alu_ready}, 32'd1);
    chk("alu_only_wa3", {27'd0, wa3}, 32'd5);
    chk("alu_only_wd3", wd3, 32'h11);
    idle(); tick();
    chk("alu_only_idle_wa3", {27'd0, wa3}, 32'd0);

    // Conflict: mem wins, ALU parks then drains
    alu_valid = 1; alu_rd = 3; alu_data = 32'hA;
    mem_valid = 1; mem_rd = 4; mem_data = 32'hB;
    tick();
    chk("conf_alu_ready", {31'd0, pre_alu_ready}, 32'd1);
    chk("conf_mem_ready", {31'd0, pre_mem_ready}, 32'd1);
    chk("conf_wa3_mem", {27'd0, wa3}, 32'd4);
    chk("conf_wd3_mem", wd3, 32'hB);
    idle(); tick();
    chk("conf_alu_blocked", {31'd0, pre_alu_ready}, 32'd0);
    chk("conf_wa3_buf", {27'd0, wa3}, 32'd3);
    chk("conf_wd3_buf", wd3, 32'hA);
    idle(); tick();

    // Starvation: buffer holds rd=7 while mem streams
    alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    mem_valid = 1; mem_rd = 1; mem_data = 32'h100;
    tick();
    alu_valid = 0;
    for (int i = 0; i < LIMIT; i++) begin
      mem_rd = 5'(2 + i); mem_data = 32'h200 + 32'(i);
      tick();
      chk("starve_mem_ready", {31'd0, pre_mem_ready}, 32'd1);
      chk("starve_mem_wa3", {27'd0, wa3}, 32'(2 + i));
    end
    mem_rd = 5'd10; mem_data = 32'h300;
    tick();
    chk("starve_forced_ready", {31'd0, pre_mem_ready}, 32'd0);
    chk("starve_forced_wa3", {27'd0, wa3}, 32'd7);
    chk("starve_forced_wd3", wd3, 32'h77);
    tick();
    chk("starve_resume_ready", {31'd0, pre_mem_ready}, 32'd1);
    chk("starve_resume_wa3", {27'd0, wa3}, 32'd10);
    idle(); tick();

    // Scoreboard
    ld_issue = 1; ld_rd = 9;
    tick();
    idle(); ra1 = 9;
    tick();
    chk("sb_busy_stall", {31'd0, pre_stall}, 32'd1);
    mem_valid = 1; mem_rd = 9; mem_data = 32'h99;
    tick();
    chk("sb_clear_cycle_stall", {31'd0, pre_stall}, 32'd1);
    chk("sb_wa3", {27'd0, wa3}, 32'd9);
    mem_valid = 0;
    tick();
    chk("sb_wa3_stall", {31'd0, pre_stall}, 32'd1);
    tick();
    chk("sb_released", {31'd0, pre_stall}, 32'd0);
    ld_issue = 1; ld_rd = 9; mem_valid = 1; mem_rd = 9; mem_data = 32'h98;
    tick();
    idle(); ra2 = 9;
    tick();
    tick();
    chk("sb_set_wins", {31'd0, pre_stall}, 32'd1);
    mem_valid = 1; mem_rd = 9; mem_data = 32'h97;
    tick();
    idle(); tick();

    // x0 handling
    alu_valid = 1; alu_rd = 0; alu_data = 32'hDEAD;
    tick();
    chk("x0_ready", {31'd0, pre_alu_ready}, 32'd1);
    chk("x0_stall", {31'd0, pre_stall}, 32'd0);
    chk("x0_wa3", {27'd0, wa3}, 32'd0);
    idle(); tick();

    // Reset mid-operation with buffer full and wa3=12
    ld_issue = 1; ld_rd = 20;
    alu_valid = 1; alu_rd = 13; alu_data = 32'h13;
    mem_valid = 1; mem_rd = 12; mem_data = 32'h12;
    tick();
    chk("mid_wa3_before", {27'd0, wa3}, 32'd12);
    idle(); ra1 = 13; ra2 = 20;
    reset = 1'b0;
    #1;
    chk("mid_rst_wa3", {27'd0, wa3}, 32'd0);
    chk("mid_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    model_reset();
    #1;
    reset = 1'b1;
    tick();
    chk("mid_after_wa3", {27'd0, wa3}, 32'd0);
    tick();
    chk("mid_after_wa3_2", {27'd0, wa3}, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      alu_valid = 1'($urandom_range(0, 1));
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      mem_valid = ($urandom_range(0, 9) < 6);
      mem_rd    = 5'($urandom_range(0, 7));
      mem_data  = $urandom;
      ld_issue  = ($urandom_range(0, 9) < 3);
      ld_rd     = 5'($urandom_range(0, 7));
      ra1       = 5'($urandom_range(0, 7));
      ra2       = 5'($urandom_range(0, 7));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
